// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = A - B) with N/Z/C/V flags, LSB first, one bit per clock.
// Define SERIAL_SUB_ADD_MODE_EN to add an 'op' input selecting add (op=0) or subtract (op=1).
module serial_subtractor #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             op,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             negative,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             c_reg;
    logic             acc_reg;
    logic             sub_reg;

    logic             b_bit;
    logic             s_bit;
    logic             c_next;
    logic             last_bit;

`ifdef SERIAL_SUB_ADD_MODE_EN
    logic             op_sel;
    assign op_sel = op;
`else
    logic             op_sel;
    assign op_sel = 1'b1;
`endif

    // Subtraction is A + ~B + 1: invert B's bit and seed the carry flop with 1.
    assign b_bit    = sub_reg ? ~b_reg[0] : b_reg[0];
    assign s_bit    = a_reg[0] ^ b_bit ^ c_reg;
    assign c_next   = (a_reg[0] & b_bit) | (a_reg[0] & c_reg) | (b_bit & c_reg);
    assign last_bit = (cnt_reg == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_reg)
            IDLE:    busy = 1'b0;
            SHIFT:   busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            res_reg  <= '0;
            cnt_reg  <= '0;
            c_reg    <= 1'b0;
            acc_reg  <= 1'b0;
            sub_reg  <= 1'b1;
            diff     <= '0;
            negative <= 1'b0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg   <= A;
                        b_reg   <= B;
                        sub_reg <= op_sel;
                        c_reg   <= op_sel;
                        cnt_reg <= '0;
                        acc_reg <= 1'b0;
                    end
                end
                SHIFT: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    res_reg <= {s_bit, res_reg[WIDTH-1:1]};
                    acc_reg <= acc_reg | s_bit;
                    c_reg   <= c_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    // Results are published only here, so they hold through later operations.
                    if (last_bit) begin
                        diff     <= {s_bit, res_reg[WIDTH-1:1]};
                        negative <= s_bit;
                        zero     <= ~(acc_reg | s_bit);
                        carry    <= c_next;
                        overflow <= c_reg ^ c_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, bit-serial two's-complement subtractor: diff = A - B, plus ARM-style N/Z/C/V flags.
- Built from one full-adder-style bit slice fed with B inverted, plus a registered carry (no-borrow) flop. Processes one bit per clock, LSB first.
- Sits beside the ALU for low-area compare/subtract. Uses a start/done handshake with the datapath controller.

Parameters:
- WIDTH, 64, operand and result width in bits (legal 2..64).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  minuend; captured on accepted start
- B  input  WIDTH  subtrahend; captured on accepted start
- busy  output  1  high in SHIFT and DONE states
- done  output  1  one-cycle pulse; diff and flags valid
- diff  output  WIDTH  A - B modulo 2^WIDTH
- negative  output  1  diff[WIDTH-1]
- zero  output  1  diff == 0
- carry  output  1  carry out of A + ~B + 1 (1 = no borrow, i.e. A >= B unsigned)
- overflow  output  1  signed overflow of A - B

Behaviour:
- Clock and reset: single clock clk. reset_n is asynchronous and active-low.
- Reset (asserted at any time, including mid-operation):
  - state=IDLE; busy=0, done=0, diff=0, negative=0, zero=0, carry=0, overflow=0.
  - Internal shift registers, bit counter and carry flop are cleared.
  - The aborted operation is discarded; no done pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On a clk edge with start=1: capture A and B into shift registers, set carry flop=1, bit counter=0, zero accumulator=0, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, each edge:
  - s = a0 ^ ~b0 ^ c.
  - c' = majority(a0, ~b0, c).
  - Shift s into result MSB; shift operands right; OR s into the zero accumulator; counter++.
  - At counter==WIDTH-1 (last bit): latch carry=c', negative=s, zero=~(acc|s), overflow=c_in_msb ^ c'. Load diff from the shift register. Go to DONE.
- DONE: done=1 for exactly this one cycle; next edge goes to IDLE.
- Latency: start sampled at edge t0; done high in the cycle after edge t0+WIDTH; outputs update at that same edge.
- Throughput: one operation per WIDTH+2 cycles.
- Handshake:
  - start in SHIFT or DONE is ignored: no queuing, no restart, no error.
  - A and B may change freely after the accepted start edge.
- Output hold: diff and flags hold their last values until the next completion or reset. They do not change during a subsequent SHIFT.
- Arithmetic: modulo 2^WIDTH, no saturation.
- Edge cases:
  - A==B gives zero=1, carry=1.
  - B=0 gives carry=1.
  - A=0, B≠0 gives carry=0.

Optional Feature:
- Macro: SERIAL_SUB_ADD_MODE_EN.
- When defined:
  - Adds input port op (1 bit, captured with A/B on accepted start).
  - op=1: subtract as above.
  - op=0: add. The bit slice uses b0 uninverted with carry flop init 0; diff = A + B; carry = unsigned carry-out; overflow = signed add overflow.
  - Latency is identical.
- When undefined: no op port; the block always subtracts.

Test Plan:
All scenarios use WIDTH=8.
- Reset/idle: reset_n low mid-SHIFT after A=0x50, B=0x20 started → all outputs 0 immediately, state IDLE, no done pulse after release.
- Basic: A=0x50, B=0x20, start 1 cycle → done pulses exactly 9 cycles after start edge; diff=0x30, N=0, Z=0, C=1, V=0.
- Borrow/zero:
  - A=0x00, B=0x01 → diff=0xFF, N=1, Z=0, C=0, V=0.
  - Then A=0x7F, B=0x7F → diff=0x00, Z=1, C=1.
- Signed overflow: A=0x80, B=0x01 → diff=0x7F, N=0, C=1, V=1. A=0x7F, B=0xFF → diff=0x80, N=1, C=0, V=1.
- Handshake: hold start=1 continuously with changing A/B → operands captured only on IDLE edges; one done per WIDTH+2 cycles. Results from the first operation hold until the second completes.
- Add mode (SERIAL_SUB_ADD_MODE_EN defined): op=0, A=0xFF, B=0x01 → diff=0x00, Z=1, C=1, V=0. op=0, A=0x7F, B=0x01 → diff=0x80, N=1, V=1.
